// File: rtl/key_led_ctrl_multi_if.sv
// key_led_ctrl_multi_if
//   Groups the per-channel key/LED signals of key_led_ctrl_multi.
//   key_in   : raw asynchronous key pins (toward the controller)
//   mode     : per-channel LED mode, 0 = follow, 1 = toggle (toward the controller)
//   led_out  : registered LED drive, 1 = lit (from the controller)
//   key_flag : one-cycle pulse per debounced press (from the controller)
//   master drives keys/mode and observes LEDs/flags; slave is the controller side.
interface key_led_ctrl_multi_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0] key_in;
  logic [CH_NUM-1:0] mode;
  logic [CH_NUM-1:0] led_out;
  logic [CH_NUM-1:0] key_flag;

  modport master (
    output key_in,
    output mode,
    input  led_out,
    input  key_flag
  );

  modport slave (
    input  key_in,
    input  mode,
    output led_out,
    output key_flag
  );
endinterface

// File: rtl/key_led_ctrl_multi.sv
// key_led_ctrl_multi
//   Multi-channel key front end: per channel a two-flop synchroniser, a
//   counter debouncer, a registered press-edge detector and an LED driver
//   that either follows the debounced key or toggles on each press.
//   Channels share nothing except the clock and reset.
// Ports
//   sys_clk : system clock, all logic on the rising edge
//   sys_rst : synchronous active-high reset
//   bus     : key_led_ctrl_multi_if.slave (key_in, mode in; led_out, key_flag out)
// Parameters
//   CH_NUM     : number of key/LED channels (>= 1)
//   CNT_MAX    : debounce terminal count (>= 1); a new level must persist
//                CNT_MAX+1 synchronised cycles before it is accepted
//   KEY_ACTIVE : pressed level of key_in
module key_led_ctrl_multi #(
  parameter int CH_NUM     = 4,
  parameter int CNT_MAX    = 999_999,
  parameter bit KEY_ACTIVE = 1'b0
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  key_led_ctrl_multi_if.slave bus
);

  localparam int                CW       = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]     CNT_TOP  = CW'(CNT_MAX);
  localparam logic [CH_NUM-1:0] ACTIVE_V = {CH_NUM{KEY_ACTIVE}};
  localparam logic [CH_NUM-1:0] RELEASED = ~ACTIVE_V;

  logic [CH_NUM-1:0]         sync1;
  logic [CH_NUM-1:0]         sync2;
  logic [CH_NUM-1:0]         stable;
  logic [CH_NUM-1:0][CW-1:0] cnt;
  logic [CH_NUM-1:0]         pressed;
  logic [CH_NUM-1:0]         pressed_d;
  logic [CH_NUM-1:0]         press_evt;
  logic [CH_NUM-1:0]         led_q;
  logic [CH_NUM-1:0]         flag_q;

  // Synchronisers come out of reset at the released level so that a key
  // held through reset is seen as a fresh transition and debounced as a press.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= bus.key_in;
      sync2 <= sync1;
    end
  end

  // Debouncer: any cycle where sync2 agrees with stable clears the count,
  // so only an uninterrupted run of CNT_MAX+1 differing cycles flips stable.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stable <= RELEASED;
      cnt    <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_TOP) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Press events are rising edges of the debounced pressed level.
  always_comb begin
    pressed   = ~(stable ^ ACTIVE_V);
    press_evt = pressed & ~pressed_d;
  end

  // Output stage. mode is used as presented on this edge, so a mode change
  // coinciding with a press is governed by the new mode.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pressed_d <= '0;
      flag_q    <= '0;
      led_q     <= '0;
    end else begin
      pressed_d <= pressed;
      flag_q    <= press_evt;
      led_q     <= (bus.mode & (led_q ^ press_evt)) | (~bus.mode & pressed);
    end
  end

  assign bus.led_out  = led_q;
  assign bus.key_flag = flag_q;

endmodule

// File: tb/tb_key_led_ctrl_multi.sv
// tb_key_led_ctrl_multi
//   Directed and random stimulus for key_led_ctrl_multi with CNT_MAX = 4,
//   giving a 7-edge key-to-output latency. Expected press flags are queued
//   with the cycle they must appear on; a monitor pops them when due.
module tb_key_led_ctrl_multi;

  localparam int CH_NUM     = 4;
  localparam int CNT_MAX    = 4;
  localparam bit KEY_ACTIVE = 1'b0;
  localparam int LAT        = CNT_MAX + 3;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;

  logic sys_clk;
  logic sys_rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   rand_phase;
  exp_t exp_q[$];

  // Reference model state, advanced on every rising edge
  logic [3:0] m_s1, m_s2, m_stab, m_prd, m_led, m_flag;
  int         m_run [4];
  logic [3:0] prev_flag;

  key_led_ctrl_multi_if #(.CH_NUM(CH_NUM)) bus ();

  key_led_ctrl_multi #(
    .CH_NUM    (CH_NUM),
    .CNT_MAX   (CNT_MAX),
    .KEY_ACTIVE(KEY_ACTIVE)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  // 10 ns clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Shared comparison helper; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] keys, input logic [3:0] md);
    sys_rst    = rst;
    bus.key_in = keys;
    bus.mode   = md;
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic expectFlag(input int at, input logic [3:0] mask);
    exp_q.push_back('{at, mask});
  endtask

  // Cycle counter plus reference model. The model counts how long sync2 has
  // disagreed with the accepted level and accepts it on the CNT_MAX+1'th
  // disagreeing cycle. It only feeds the scoreboard during the random phase.
  always @(posedge sys_clk) begin
    logic pr, ev;
    cyc++;
    if (sys_rst) begin
      m_s1   = 4'hF;
      m_s2   = 4'hF;
      m_stab = 4'hF;
      m_prd  = 4'h0;
      m_led  = 4'h0;
      m_flag = 4'h0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pr        = (m_stab[i] == KEY_ACTIVE);
        ev        = pr && !m_prd[i];
        m_flag[i] = ev;
        m_led[i]  = bus.mode[i] ? (m_led[i] ^ ev) : pr;
        m_prd[i]  = pr;
        if (m_s2[i] != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == CNT_MAX + 1) begin
            m_stab[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = bus.key_in[i];
      end
    end
    if (rand_phase && m_flag != 4'h0) expectFlag(cyc, m_flag);
  end

  // Monitor: on the falling edge, a due expectation is popped and compared;
  // with nothing due, key_flag must be quiet. Flags must never last 2 cycles.
  always @(negedge sys_clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checkOutput("missed_flag", 4'h0, e.mask);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checkOutput("key_flag", bus.key_flag, e.mask);
    end else begin
      checkOutput("unexpected_flag", bus.key_flag, 4'h0);
    end
    checkOutput("flag_width", bus.key_flag & prev_flag, 4'h0);
    prev_flag = bus.key_flag;
    if (rand_phase) checkOutput("led_model", bus.led_out, m_led);
  end

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed phases followed by random stimulus
  initial begin
    logic [3:0] keys;
    logic [3:0] md;
    logic       rst_r;
    cyc        = 0;
    n_checks   = 0;
    n_fail     = 0;
    rand_phase = 1'b0;
    prev_flag  = 4'h0;
    keys       = 4'hF;
    md         = 4'h0;
    applyStimulus(1'b1, keys, md);

    // Reset, then key 0 held from the first edge out of reset
    tick(3);
    checkOutput("reset_led", bus.led_out, 4'h0);
    checkOutput("reset_flag", bus.key_flag, 4'h0);
    keys = 4'b1110;
    applyStimulus(1'b0, keys, md);
    expectFlag(cyc + LAT + 1, 4'b0001);
    tick(LAT);
    checkOutput("led0_before_latency", {3'b0, bus.led_out[0]}, 4'h0);
    tick(1);
    checkOutput("led0_after_latency", {3'b0, bus.led_out[0]}, 4'h1);
    keys = 4'hF;
    applyStimulus(1'b0, keys, md);
    tick(15);
    checkOutput("led0_release", bus.led_out, 4'h0);

    // Bounce on key 1: 4 low, 1 high, 4 low must be rejected
    keys = 4'b1101;
    applyStimulus(1'b0, keys, md);
    tick(4);
    keys = 4'hF;
    applyStimulus(1'b0, keys, md);
    tick(1);
    keys = 4'b1101;
    applyStimulus(1'b0, keys, md);
    tick(4);
    keys = 4'hF;
    applyStimulus(1'b0, keys, md);
    tick(20);
    checkOutput("bounce_led1", bus.led_out, 4'h0);
    // Clean 10-cycle press on key 1
    keys = 4'b1101;
    applyStimulus(1'b0, keys, md);
    expectFlag(cyc + LAT + 1, 4'b0010);
    tick(10);
    keys = 4'hF;
    applyStimulus(1'b0, keys, md);
    tick(15);
    checkOutput("clean_led1_release", bus.led_out, 4'h0);

    // Toggle mode on channel 2: LED goes 1, 0, 1 only at press edges
    md = 4'b0100;
    applyStimulus(1'b0, keys, md);
    tick(2);
    for (int i = 0; i < 3; i++) begin
      logic [3:0] before_v, after_v;
      before_v = (i == 1) ? 4'h1 : 4'h0;
      after_v  = (i == 1) ? 4'h0 : 4'h1;
      keys = 4'b1011;
      applyStimulus(1'b0, keys, md);
      expectFlag(cyc + LAT + 1, 4'b0100);
      tick(LAT);
      checkOutput("toggle_led2_pre", {3'b0, bus.led_out[2]}, before_v);
      tick(1);
      checkOutput("toggle_led2_post", {3'b0, bus.led_out[2]}, after_v);
      tick(7);
      keys = 4'hF;
      applyStimulus(1'b0, keys, md);
      tick(15);
      checkOutput("toggle_led2_release", {3'b0, bus.led_out[2]}, after_v);
    end

    // Mode switching on channel 3
    md = 4'b1100;
    keys = 4'b0111;
    applyStimulus(1'b0, keys, md);
    expectFlag(cyc + LAT + 1, 4'b1000);
    tick(LAT + 1);
    checkOutput("mode_led3_press", {3'b0, bus.led_out[3]}, 4'h1);
    tick(4);
    keys = 4'hF;
    applyStimulus(1'b0, keys, md);
    tick(15);
    checkOutput("mode_led3_held", {3'b0, bus.led_out[3]}, 4'h1);
    md = 4'b0100;
    applyStimulus(1'b0, keys, md);
    tick(1);
    checkOutput("mode_led3_follow", {3'b0, bus.led_out[3]}, 4'h0);
    md = 4'b1100;
    applyStimulus(1'b0, keys, md);
    tick(5);
    checkOutput("mode_led3_hold0", {3'b0, bus.led_out[3]}, 4'h0);

    // All four keys pressed together
    keys = 4'b0000;
    applyStimulus(1'b0, keys, md);
    expectFlag(cyc + LAT + 1, 4'b1111);
    tick(LAT + 1);
    checkOutput("simul_led", bus.led_out, 4'b1011);
    tick(4);
    keys = 4'hF;
    applyStimulus(1'b0, keys, md);
    tick(15);
    checkOutput("simul_led_release", bus.led_out, 4'b1000);

    // Reset mid-count on key 0, key still held after reset
    keys = 4'b1110;
    applyStimulus(1'b0, keys, md);
    tick(5);
    applyStimulus(1'b1, keys, md);
    tick(3);
    checkOutput("midreset_led", bus.led_out, 4'h0);
    applyStimulus(1'b0, keys, md);
    expectFlag(cyc + LAT + 1, 4'b0001);
    tick(LAT + 1);
    checkOutput("midreset_led_after", bus.led_out, 4'b0001);
    keys = 4'hF;
    applyStimulus(1'b0, keys, md);
    tick(15);

    // Random keys, modes and occasional resets against the reference model
    rand_phase = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      rst_r = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) keys[b] = ~keys[b];
        if ($urandom_range(0, 127) == 0) md[b] = ~md[b];
      end
      applyStimulus(rst_r, keys, md);
      tick(1);
    end
    keys = 4'hF;
    applyStimulus(1'b0, keys, md);
    tick(30);
    rand_phase = 1'b0;
    tick(1);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
